// File: rtl/pc_pkg.sv
// pc_pkg: shared branch-mode and next-PC-source encodings plus branch evaluation.
// Exports: BR_* (br_mode codes), SRC_* (pc_src codes), br_taken(mode, zero, neg).
package pc_pkg;
    localparam logic [1:0] BR_BEQ  = 2'd0;
    localparam logic [1:0] BR_BNE  = 2'd1;
    localparam logic [1:0] BR_BLEZ = 2'd2;
    localparam logic [1:0] BR_BGTZ = 2'd3;
    localparam logic [1:0] SRC_ALU_RES = 2'd0;
    localparam logic [1:0] SRC_ALU_OUT = 2'd1;
    localparam logic [1:0] SRC_JUMP    = 2'd2;
    localparam logic [1:0] SRC_RAS     = 2'd3;
    function automatic logic br_taken(input logic [1:0] mode, input logic z, input logic n);
        return mode == BR_BEQ  ? z :
               mode == BR_BNE  ? !z :
               mode == BR_BLEZ ? (z | n) : !(z | n);
    endfunction
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack with sticky overflow/underflow error.
// Ports: clk, rst (async active-low), push/push_data, pop, pop_data (current top),
//        full, empty (registered from next count), err (sticky).
module pc_ras #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d, top_idx, waddr;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, full_d, empty_q, empty_d, err_q, err_d, we;
    always_comb begin
        top_idx  = ptr_q - PW'(1);
        pop_data = mem_q[top_idx];
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        we       = 1'b0;
        waddr    = ptr_q;
        // push+pop on a non-empty stack rewrites the top slot in place
        if (push && pop && !empty_q) begin
            we    = 1'b1;
            waddr = top_idx;
        end else if (push) begin
            // when full, ptr already addresses the oldest slot, so it is overwritten
            we    = 1'b1;
            ptr_d = ptr_q + PW'(1);
            cnt_d = full_q ? cnt_q : cnt_q + CW'(1);
            err_d = err_q | full_q | pop;
        end else if (pop) begin
            ptr_d = empty_q ? ptr_q : top_idx;
            cnt_d = empty_q ? cnt_q : cnt_q - CW'(1);
            err_d = err_q | empty_q;
        end
        full_d  = cnt_d == CW'(DEPTH);
        empty_d = cnt_d == '0;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= push_data;
    end
    assign full  = full_q;
    assign empty = empty_q;
    assign err   = err_q;
endmodule

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: program counter with branch evaluation, jumps, traps and a return-address stack.
// Ports: clk, rst (async active-low), PCWrite, PCWriteCond, br_mode, zero, neg, pc_src,
//        alu_result, alu_out, jidx, ras_push, trap -> PC_Out, ras_full, ras_empty, ras_err.
module pc_seq_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'('h80),
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCWrite,
    input  logic             PCWriteCond,
    input  logic [1:0]       br_mode,
    input  logic             zero,
    input  logic             neg,
    input  logic [1:0]       pc_src,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [25:0]      jidx,
    input  logic             ras_push,
    input  logic             trap,
    output logic [WIDTH-1:0] PC_Out,
    output logic             ras_full,
    output logic             ras_empty,
    output logic             ras_err
);
    localparam logic [63:0] LOW28 = 64'h0FFF_FFFF;
    logic [WIDTH-1:0] pc_q, pc_d, jmp_tgt, ras_top, ras_val, sel_val, ret_addr;
    logic             take_br, pc_upd, push, pop;
    always_comb begin
        // keep PC bits above 27, replace the low 28 with {jidx, 2'b00}
        jmp_tgt  = (pc_q & ~WIDTH'(LOW28)) | WIDTH'({jidx, 2'b00});
        ret_addr = pc_q + WIDTH'(4);
        take_br  = PCWriteCond & br_taken(br_mode, zero, neg);
        pc_upd   = PCWrite | take_br;
        push     = !trap & PCWrite & ras_push;
        pop      = !trap & pc_upd & (pc_src == SRC_RAS);
        ras_val  = ras_empty ? RESET_VEC : ras_top;
        sel_val  = pc_src == SRC_ALU_RES ? alu_result :
                   pc_src == SRC_ALU_OUT ? alu_out :
                   pc_src == SRC_JUMP    ? jmp_tgt : ras_val;
        pc_d     = trap ? TRAP_VEC : pc_upd ? sel_val : pc_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_q <= RESET_VEC;
        else      pc_q <= pc_d;
    end
    pc_ras #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (ret_addr),
        .pop_data  (ras_top),
        .full      (ras_full),
        .empty     (ras_empty),
        .err       (ras_err)
    );
    assign PC_Out = pc_q;
endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed self-checking bench for pc_seq_unit with default parameters.
module tb_pc_seq_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        PCWrite = 1'b0, PCWriteCond = 1'b0, zero = 1'b0, neg = 1'b0;
    logic        ras_push = 1'b0, trap = 1'b0;
    logic [1:0]  br_mode = 2'd0, pc_src = 2'd0;
    logic [31:0] alu_result = '0, alu_out = '0;
    logic [25:0] jidx = '0;
    logic [31:0] PC_Out;
    logic        ras_full, ras_empty, ras_err;
    int          n_cmp = 0;
    int          n_bad = 0;

    pc_seq_unit dut (
        .clk         (clk),
        .rst         (rst),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .br_mode     (br_mode),
        .zero        (zero),
        .neg         (neg),
        .pc_src      (pc_src),
        .alu_result  (alu_result),
        .alu_out     (alu_out),
        .jidx        (jidx),
        .ras_push    (ras_push),
        .trap        (trap),
        .PC_Out      (PC_Out),
        .ras_full    (ras_full),
        .ras_empty   (ras_empty),
        .ras_err     (ras_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_pc", PC_Out, 0);
        chk("rst_empty", ras_empty, 1);
        chk("rst_full", ras_full, 0);
        chk("rst_err", ras_err, 0);
        rst = 1'b1;
        PCWrite = 1'b1; alu_result = 32'h20;
        tick();
        chk("first_load", PC_Out, 32'h20);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_pc", PC_Out, 0);
        chk("async_rst_empty", ras_empty, 1);
        alu_result = 32'h4;
        #1 rst = 1'b1;
        tick();
        chk("post_rst_pc", PC_Out, 32'h4);
        PCWrite = 1'b0; PCWriteCond = 1'b1; br_mode = 2'd1; zero = 1'b1; alu_out = 32'h40; pc_src = 2'd1;
        tick();
        chk("bne_hold", PC_Out, 32'h4);
        zero = 1'b0;
        tick();
        chk("bne_taken", PC_Out, 32'h40);
        br_mode = 2'd2; neg = 1'b1; alu_out = 32'h60;
        tick();
        chk("blez_taken", PC_Out, 32'h60);
        br_mode = 2'd3; alu_out = 32'h70;
        tick();
        chk("bgtz_hold", PC_Out, 32'h60);
        neg = 1'b0;
        tick();
        chk("bgtz_taken", PC_Out, 32'h70);
        br_mode = 2'd0; alu_out = 32'h78;
        tick();
        chk("beq_hold", PC_Out, 32'h70);
        PCWriteCond = 1'b0;
        tick();
        chk("idle_hold", PC_Out, 32'h70);
        PCWrite = 1'b1; pc_src = 2'd0; alu_result = 32'h100;
        tick();
        chk("load_100", PC_Out, 32'h100);
        pc_src = 2'd2; jidx = 26'h10; ras_push = 1'b1;
        tick();
        chk("call_pc", PC_Out, 32'h40);
        chk("call_not_empty", ras_empty, 0);
        ras_push = 1'b0; pc_src = 2'd3;
        tick();
        chk("ret_pc", PC_Out, 32'h104);
        chk("ret_empty", ras_empty, 1);
        pc_src = 2'd0; ras_push = 1'b1;
        alu_result = 32'h200; tick();
        alu_result = 32'h300; tick();
        alu_result = 32'h400; tick();
        alu_result = 32'h500; tick();
        chk("four_full", ras_full, 1);
        chk("four_no_err", ras_err, 0);
        alu_result = 32'h600; tick();
        chk("ovf_full", ras_full, 1);
        chk("ovf_err", ras_err, 1);
        ras_push = 1'b0; pc_src = 2'd3;
        tick(); chk("pop1", PC_Out, 32'h504);
        tick(); chk("pop2", PC_Out, 32'h404);
        tick(); chk("pop3", PC_Out, 32'h304);
        tick(); chk("pop4", PC_Out, 32'h204);
        chk("pop4_empty", ras_empty, 1);
        chk("pop4_not_full", ras_full, 0);
        rst = 1'b0;
        #2;
        chk("rst_err_clear", ras_err, 0);
        rst = 1'b1;
        pc_src = 2'd0; alu_result = 32'h300;
        tick();
        chk("load_300", PC_Out, 32'h300);
        pc_src = 2'd3;
        tick();
        chk("udf_pc", PC_Out, 0);
        chk("udf_err", ras_err, 1);
        chk("udf_empty", ras_empty, 1);
        pc_src = 2'd0; ras_push = 1'b1; alu_result = 32'h500;
        tick();
        chk("push_pc", PC_Out, 32'h500);
        pc_src = 2'd3;
        tick();
        chk("pushpop_pc", PC_Out, 32'h4);
        chk("pushpop_count", ras_empty, 0);
        ras_push = 1'b0;
        tick();
        chk("pushpop_newtop", PC_Out, 32'h504);
        chk("pushpop_empty", ras_empty, 1);
        pc_src = 2'd0; ras_push = 1'b1; alu_result = 32'h10;
        tick();
        chk("pre_trap_pc", PC_Out, 32'h10);
        trap = 1'b1; pc_src = 2'd3;
        tick();
        chk("trap_pc", PC_Out, 32'h80);
        chk("trap_not_empty", ras_empty, 0);
        chk("trap_not_full", ras_full, 0);
        trap = 1'b0; ras_push = 1'b0;
        tick();
        chk("trap_stack_kept", PC_Out, 32'h508);
        chk("trap_then_empty", ras_empty, 1);
        pc_src = 2'd0; alu_result = 32'hF000_0000;
        tick();
        pc_src = 2'd2; jidx = 26'h3FF_FFFF;
        tick();
        chk("jump_upper_bits", PC_Out, 32'hFFFF_FFFC);
        PCWrite = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
